// File: rtl/control_sequencer_pkg.sv
// ctrl_pkg: opcode map, instruction classes and sequencer states shared by the
// control unit and its decoder.
package ctrl_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        C_ALU3, C_ALUI, C_ALU2, C_MULDIV, C_LD, C_LDI, C_ST, C_BR, C_SINGLE, C_NOP, C_HALT, C_ILLEGAL
    } cls_e;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_T3, S_T4, S_T5, S_T6, S_T7, S_STOPPED, S_HALTED
    } state_e;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/status inputs and datapath strobes between
// the control unit (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5
);
    logic [DATA_W-1:0] ir;
    logic con_ff, mem_ready, stop;
    logic pco, pci, inc_pc, mari, mdri, mdro, iri, mem_read, mem_write;
    logic gra, grb, grc, rin, rout, bain;
    logic ryi, rzli, rzhi, rzlo, rzho, hii, hio, loi, loo;
    logic ipo, opi, csigno, coni;
    logic [OPC_W-1:0] alu_op;
    logic run, illegal, bus_error;

    modport master (
        input  ir, con_ff, mem_ready, stop,
        output pco, pci, inc_pc, mari, mdri, mdro, iri, mem_read, mem_write,
        output gra, grb, grc, rin, rout, bain,
        output ryi, rzli, rzhi, rzlo, rzho, hii, hio, loi, loo,
        output ipo, opi, csigno, coni, alu_op, run, illegal, bus_error
    );

    modport slave (
        output ir, con_ff, mem_ready, stop,
        input  pco, pci, inc_pc, mari, mdri, mdro, iri, mem_read, mem_write,
        input  gra, grb, grc, rin, rout, bain,
        input  ryi, rzli, rzhi, rzlo, rzho, hii, hio, loi, loo,
        input  ipo, opi, csigno, coni, alu_op, run, illegal, bus_error
    );
endinterface

// File: rtl/control_sequencer_decode.sv
// ctrl_decode: maps an opcode onto its instruction class; any opcode outside
// the defined map, including set bits above the 5-bit map, is illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opc_i,
    output cls_e             cls_o
);
    logic       hi;
    logic [4:0] op;

    assign hi = (opc_i >> 5) != '0;
    assign op = opc_i[4:0];

    always_comb begin
        cls_o = C_ILLEGAL;
        case (op)
            OP_LD:  cls_o = C_LD;
            OP_LDI: cls_o = C_LDI;
            OP_ST:  cls_o = C_ST;
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: cls_o = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI: cls_o = C_ALUI;
            OP_NEG, OP_NOT: cls_o = C_ALU2;
            OP_MUL, OP_DIV: cls_o = C_MULDIV;
            OP_BR:  cls_o = C_BR;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: cls_o = C_SINGLE;
            OP_NOP:  cls_o = C_NOP;
            OP_HALT: cls_o = C_HALT;
            default: cls_o = C_ILLEGAL;
        endcase
        if (hi) cls_o = C_ILLEGAL;
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute sequencer driving the datapath
// strobes, with memory wait/timeout, stop at instruction boundary and halt/trap.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input logic                clock,
    input logic                reset,
    control_sequencer_if.master bus
);
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             illegal_q, illegal_d, bus_error_q, bus_error_d;
    logic             last, mem_st, tmo;
    logic [OPC_W-1:0] opc;
    logic [4:0]       op5;
    cls_e             cls;

    assign opc = bus.ir[DATA_W-1 -: OPC_W];
    assign op5 = opc[4:0];

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (.opc_i(opc), .cls_o(cls));

    assign mem_st = state_q == S_FETCH1 || (state_q == S_T6 && cls == C_LD) || (state_q == S_T7 && cls == C_ST);
    // A mem_ready in the final allowed wait cycle completes the access rather than timing out.
    assign tmo    = MEM_TIMEOUT > 0 && mem_st && !bus.mem_ready && cnt_q == CW'(MEM_TIMEOUT - 1);
    assign cnt_d  = mem_st ? cnt_q + 1'b1 : '0;

    assign bus.run       = !(state_q inside {S_RESET, S_STOPPED, S_HALTED});
    assign bus.illegal   = illegal_q;
    assign bus.bus_error = bus_error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        last        = 1'b0;
        {bus.pco, bus.pci, bus.inc_pc, bus.mari, bus.mdri, bus.mdro, bus.iri, bus.mem_read, bus.mem_write} = '0;
        {bus.gra, bus.grb, bus.grc, bus.rin, bus.rout, bus.bain} = '0;
        {bus.ryi, bus.rzli, bus.rzhi, bus.rzlo, bus.rzho, bus.hii, bus.hio, bus.loi, bus.loo} = '0;
        {bus.ipo, bus.opi, bus.csigno, bus.coni} = '0;
        bus.alu_op  = '0;
        case (state_q)
            S_RESET:  state_d = S_FETCH0;
            S_FETCH0: begin
                {bus.pco, bus.mari, bus.inc_pc} = '1;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                bus.mem_read = 1'b1;
                bus.mdri     = bus.mem_ready;
                state_d      = bus.mem_ready ? S_FETCH2 : S_FETCH1;
            end
            S_FETCH2: begin
                {bus.mdro, bus.iri} = '1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    C_ALU3, C_ALUI:   {bus.grb, bus.rout, bus.ryi} = '1;
                    C_ALU2: begin
                        {bus.grb, bus.rout, bus.rzli} = '1;
                        bus.alu_op = opc;
                    end
                    C_MULDIV:         {bus.gra, bus.rout, bus.ryi} = '1;
                    C_LD, C_LDI, C_ST: {bus.grb, bus.bain, bus.rout, bus.ryi} = '1;
                    C_BR:             {bus.gra, bus.rout, bus.coni} = '1;
                    C_SINGLE: begin
                        last     = 1'b1;
                        bus.gra  = 1'b1;
                        bus.rout = op5 == OP_JR || op5 == OP_OUT;
                        bus.rin  = op5 == OP_IN || op5 == OP_MFHI || op5 == OP_MFLO;
                        bus.pci  = op5 == OP_JR;
                        bus.ipo  = op5 == OP_IN;
                        bus.opi  = op5 == OP_OUT;
                        bus.hio  = op5 == OP_MFHI;
                        bus.loo  = op5 == OP_MFLO;
                    end
                    C_NOP:  last = 1'b1;
                    C_HALT: state_d = S_HALTED;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALTED;
                    end
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    C_ALU3: begin
                        {bus.grc, bus.rout, bus.rzli} = '1;
                        bus.alu_op = opc;
                    end
                    C_ALUI: begin
                        {bus.csigno, bus.rzli} = '1;
                        bus.alu_op = opc;
                    end
                    C_ALU2: begin
                        {bus.rzlo, bus.gra, bus.rin} = '1;
                        last = 1'b1;
                    end
                    C_MULDIV: begin
                        {bus.grb, bus.rout, bus.rzli, bus.rzhi} = '1;
                        bus.alu_op = opc;
                    end
                    C_LD, C_LDI, C_ST: begin
                        {bus.csigno, bus.rzli} = '1;
                        bus.alu_op = OPC_W'(ALU_ADD);
                    end
                    C_BR:    {bus.pco, bus.ryi} = '1;
                    default: state_d = S_FETCH0;
                endcase
            end
            S_T5: begin
                state_d = S_T6;
                case (cls)
                    C_ALU3, C_ALUI, C_LDI: begin
                        {bus.rzlo, bus.gra, bus.rin} = '1;
                        last = 1'b1;
                    end
                    C_MULDIV:   {bus.rzlo, bus.loi} = '1;
                    C_LD, C_ST: {bus.rzlo, bus.mari} = '1;
                    C_BR: begin
                        {bus.csigno, bus.rzli} = '1;
                        bus.alu_op = OPC_W'(ALU_ADD);
                    end
                    default: state_d = S_FETCH0;
                endcase
            end
            S_T6: begin
                state_d = S_T7;
                case (cls)
                    C_MULDIV: begin
                        {bus.rzho, bus.hii} = '1;
                        last = 1'b1;
                    end
                    C_LD: begin
                        bus.mem_read = 1'b1;
                        bus.mdri     = bus.mem_ready;
                        state_d      = bus.mem_ready ? S_T7 : S_T6;
                    end
                    C_BR: begin
                        bus.rzlo = 1'b1;
                        bus.pci  = bus.con_ff;
                        last     = 1'b1;
                    end
                    C_ST:    {bus.gra, bus.rout, bus.mdri} = '1;
                    default: state_d = S_FETCH0;
                endcase
            end
            S_T7: begin
                state_d = S_FETCH0;
                case (cls)
                    C_LD: begin
                        {bus.mdro, bus.gra, bus.rin} = '1;
                        last = 1'b1;
                    end
                    C_ST: begin
                        bus.mem_write = 1'b1;
                        state_d       = S_T7;
                        last          = bus.mem_ready;
                    end
                    default: state_d = S_FETCH0;
                endcase
            end
            S_STOPPED: state_d = bus.stop ? S_STOPPED : S_FETCH0;
            default:   state_d = state_q;
        endcase
        if (last) state_d = bus.stop ? S_STOPPED : S_FETCH0;
        if (tmo) begin
            state_d     = S_HALTED;
            bus_error_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-cycle vectors for control_sequencer; each
// row gives the inputs for one cycle and the strobes expected in that cycle.
module tb_control_sequencer;
    logic clock, reset;
    int   errors = 0;
    int   checks = 0;

    control_sequencer_if #(.DATA_W(32), .OPC_W(5)) bus ();

    control_sequencer #(.DATA_W(32), .OPC_W(5), .MEM_TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [27:0] PCO  = 28'h1 << 27, PCI  = 28'h1 << 26, INC  = 28'h1 << 25, MARI = 28'h1 << 24;
    localparam logic [27:0] MDRI = 28'h1 << 23, MDRO = 28'h1 << 22, IRI  = 28'h1 << 21, RD   = 28'h1 << 20;
    localparam logic [27:0] WR   = 28'h1 << 19, GRA  = 28'h1 << 18, GRB  = 28'h1 << 17, GRC  = 28'h1 << 16;
    localparam logic [27:0] RIN  = 28'h1 << 15, ROUT = 28'h1 << 14, BAIN = 28'h1 << 13, RYI  = 28'h1 << 12;
    localparam logic [27:0] RZLI = 28'h1 << 11, RZHI = 28'h1 << 10, RZLO = 28'h1 << 9,  RZHO = 28'h1 << 8;
    localparam logic [27:0] HII  = 28'h1 << 7,  HIO  = 28'h1 << 6,  LOI  = 28'h1 << 5,  LOO  = 28'h1 << 4;
    localparam logic [27:0] IPO  = 28'h1 << 3,  OPI  = 28'h1 << 2,  CSG  = 28'h1 << 1,  CONI = 28'h1;
    localparam logic [27:0] FE0 = PCO | MARI | INC, FE1 = RD | MDRI, FE2 = MDRO | IRI;

    typedef struct {
        logic        r, s, c;
        logic [35:0] e;
    } row_t;

    function automatic row_t mk(logic [27:0] st, logic [4:0] alu = 5'd0, logic r = 1'b1, logic s = 1'b0,
                                logic c = 1'b0, logic run = 1'b1, logic ill = 1'b0, logic be = 1'b0);
        row_t x;
        x.r = r;
        x.s = s;
        x.c = c;
        x.e = {st, alu, run, ill, be};
        return x;
    endfunction

    function automatic logic [35:0] obs();
        return {bus.pco, bus.pci, bus.inc_pc, bus.mari, bus.mdri, bus.mdro, bus.iri, bus.mem_read, bus.mem_write,
                bus.gra, bus.grb, bus.grc, bus.rin, bus.rout, bus.bain,
                bus.ryi, bus.rzli, bus.rzhi, bus.rzlo, bus.rzho, bus.hii, bus.hio, bus.loi, bus.loo,
                bus.ipo, bus.opi, bus.csigno, bus.coni, bus.alu_op, bus.run, bus.illegal, bus.bus_error};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.stop = 1'b0;
        bus.con_ff = 1'b0;
        @(posedge clock); #2;
        checks++;
        if (obs() !== 36'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs(), 36'h0);
        end
        reset = 1'b0;
        @(posedge clock); #2;
        checks++;
        if (obs() !== {FE0, 5'd0, 3'b100}) begin
            errors++;
            $display("FAIL reset_fetch0 got=%h exp=%h", obs(), {FE0, 5'd0, 3'b100});
        end
    endtask

    task automatic test_alu3();
        row_t q[$];
        bus.ir = 32'h18918000;
        q = '{mk(FE1), mk(FE2), mk(GRB | ROUT | RYI), mk(GRC | ROUT | RZLI, 5'd3), mk(RZLO | GRA | RIN), mk(FE0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL add row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_load();
        row_t q[$];
        bus.ir = 32'h00000000;
        q = '{mk(FE1), mk(FE2), mk(GRB | BAIN | ROUT | RYI), mk(CSG | RZLI, 5'd3), mk(RZLO | MARI),
              mk(RD, 5'd0, 1'b0), mk(RD, 5'd0, 1'b0), mk(RD, 5'd0, 1'b0), mk(RD | MDRI, 5'd0, 1'b1),
              mk(MDRO | GRA | RIN), mk(FE0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL ld row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_store();
        row_t q[$];
        bus.ir = 32'h10000000;
        q = '{mk(FE1), mk(FE2), mk(GRB | BAIN | ROUT | RYI), mk(CSG | RZLI, 5'd3), mk(RZLO | MARI),
              mk(GRA | ROUT | MDRI), mk(WR, 5'd0, 1'b0), mk(WR, 5'd0, 1'b1), mk(FE0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL st row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_branch();
        row_t q[$];
        bus.ir = 32'h98000000;
        q = '{mk(FE1), mk(FE2), mk(GRA | ROUT | CONI), mk(PCO | RYI), mk(CSG | RZLI, 5'd3),
              mk(RZLO, 5'd0, 1'b1, 1'b0, 1'b0), mk(FE0),
              mk(FE1), mk(FE2), mk(GRA | ROUT | CONI), mk(PCO | RYI), mk(CSG | RZLI, 5'd3),
              mk(RZLO | PCI, 5'd0, 1'b1, 1'b0, 1'b1), mk(FE0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL br row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_muldiv();
        row_t q[$];
        bus.ir = 32'h78000000;
        q = '{mk(FE1), mk(FE2), mk(GRA | ROUT | RYI), mk(GRB | ROUT | RZLI | RZHI, 5'd15),
              mk(RZLO | LOI), mk(RZHO | HII), mk(FE0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL mul row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0]  ops  [6] = '{8'hA0, 8'hB0, 8'hB8, 8'hC0, 8'hC8, 8'hD0};
        logic [27:0] exps [6] = '{GRA | ROUT | PCI, IPO | GRA | RIN, GRA | ROUT | OPI,
                                  HIO | GRA | RIN, LOO | GRA | RIN, 28'h0};
        for (int k = 0; k < 6; k++) begin
            row_t q[$];
            bus.ir = {ops[k], 24'h0};
            q = '{mk(FE1), mk(FE2), mk(exps[k]), mk(FE0)};
            foreach (q[i]) begin
                @(posedge clock); #1;
                bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
                checks++;
                if (obs() !== q[i].e) begin
                    errors++;
                    $display("FAIL single op=%h row%0d got=%h exp=%h", ops[k], i, obs(), q[i].e);
                end
            end
        end
    endtask

    task automatic test_stop();
        row_t q[$];
        bus.ir = 32'h18918000;
        q = '{mk(FE1), mk(FE2), mk(GRB | ROUT | RYI), mk(GRC | ROUT | RZLI, 5'd3, 1'b1, 1'b1),
              mk(RZLO | GRA | RIN, 5'd0, 1'b1, 1'b1), mk(28'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0),
              mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), mk(FE0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL stop row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_ready_at_timeout();
        row_t q[$];
        bus.ir = 32'hD0000000;
        for (int k = 0; k < 15; k++) q.push_back(mk(RD, 5'd0, 1'b0));
        q.push_back(mk(FE1));
        q.push_back(mk(FE2));
        q.push_back(mk(28'h0));
        q.push_back(mk(FE0));
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL ready_at_limit row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_timeout();
        row_t q[$];
        for (int k = 0; k < 16; k++) q.push_back(mk(RD, 5'd0, 1'b0));
        for (int k = 0; k < 3; k++) q.push_back(mk(28'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL timeout row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_halt();
        row_t q[$];
        bus.ir = 32'hD8000000;
        q = '{mk(FE1), mk(FE2), mk(28'h0), mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0),
              mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL halt row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_illegal();
        row_t q[$];
        bus.ir = 32'hF8000000;
        q = '{mk(FE1), mk(FE2), mk(28'h0), mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1),
              mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), mk(28'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL illegal row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t q[$];
        bus.ir = 32'h00000000;
        q = '{mk(FE1), mk(FE2), mk(GRB | BAIN | ROUT | RYI), mk(CSG | RZLI, 5'd3), mk(RZLO | MARI),
              mk(RD, 5'd0, 1'b0)};
        foreach (q[i]) begin
            @(posedge clock); #1;
            bus.mem_ready = q[i].r; bus.stop = q[i].s; bus.con_ff = q[i].c; #1;
            checks++;
            if (obs() !== q[i].e) begin
                errors++;
                $display("FAIL reset_mid row%0d got=%h exp=%h", i, obs(), q[i].e);
            end
        end
        reset = 1'b1;
        @(posedge clock); #1;
        bus.mem_ready = 1'b1; #1;
        checks++;
        if (obs() !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid_zero got=%h exp=%h", obs(), 36'h0);
        end
        reset = 1'b0;
        @(posedge clock); #2;
        checks++;
        if (obs() !== {FE0, 5'd0, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_fetch0 got=%h exp=%h", obs(), {FE0, 5'd0, 3'b100});
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ir = '0;
        bus.mem_ready = 1'b1;
        bus.stop = 1'b0;
        bus.con_ff = 1'b0;
        test_reset();
        test_alu3();
        test_load();
        test_store();
        test_branch();
        test_muldiv();
        test_single();
        test_stop();
        test_ready_at_timeout();
        test_timeout();
        test_reset();
        test_halt();
        test_reset();
        test_illegal();
        test_reset();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
